// File: rtl/mmu_pkg.sv
// Types shared by the TLBs and the MMU page walker.
package mmu_pkg;

    localparam int PAGE_OFFSET_BITS = 12;
    localparam int VPN_BITS         = 36;
    localparam int PPN_BITS         = 52;

    // RISC-V style DAGUXWRV, bit 7 down to bit 0
    typedef struct packed {
        logic dirty;
        logic accessed;
        logic glbl;
        logic user;
        logic exec;
        logic write;
        logic read;
        logic valid;
    } tlb_perm_bits;

    typedef enum logic [1:0] {
        TLB_IDLE,
        TLB_WALK,
        TLB_RESP
    } tlb_state_t;

    function automatic logic tlb_fault(tlb_perm_bits p, logic wr, logic ex);
        return !p.valid | (wr & !p.write) | (ex & !p.exec) | (!wr & !ex & !p.read);
    endfunction

endpackage

// File: rtl/tlb_if.sv
// Requester, walker and control signals of one TLB instance.
interface tlb_if;
    import mmu_pkg::*;

    logic         req_valid;
    logic [63:0]  req_addr;
    logic         req_write;
    logic         req_exec;
    logic         resp_valid;
    logic [63:0]  resp_addr;
    tlb_perm_bits resp_perms;
    logic         resp_fault;
    logic         walk_req_valid;
    logic [63:0]  walk_req_addr;
    logic         walk_resp_valid;
    logic [63:0]  walk_resp_addr;
    tlb_perm_bits walk_resp_perms;
    logic [63:0]  root_pt_addr;
    logic         flush;

    modport slave (
        input  req_valid, req_addr, req_write, req_exec,
        output resp_valid, resp_addr, resp_perms, resp_fault,
        output walk_req_valid, walk_req_addr,
        input  walk_resp_valid, walk_resp_addr, walk_resp_perms,
        input  root_pt_addr, flush
    );

    modport master (
        output req_valid, req_addr, req_write, req_exec,
        input  resp_valid, resp_addr, resp_perms, resp_fault,
        input  walk_req_valid, walk_req_addr,
        output walk_resp_valid, walk_resp_addr, walk_resp_perms,
        output root_pt_addr, flush
    );

endinterface

// File: rtl/tlb_cam.sv
// Fully associative entry store: parallel tag match, one write port, clear-all.
module tlb_cam
    import mmu_pkg::*;
#(
    parameter  int ENTRIES = 8,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [VPN_BITS-1:0] lookup_vpn,
    output logic                hit,
    output logic [PPN_BITS-1:0] hit_ppn,
    output tlb_perm_bits        hit_perms,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [VPN_BITS-1:0] wr_vpn,
    input  logic [PPN_BITS-1:0] wr_ppn,
    input  tlb_perm_bits        wr_perms,
    input  logic                clear_all
);

    logic [ENTRIES-1:0]               valid;
    logic [ENTRIES-1:0][VPN_BITS-1:0] vpn;
    logic [ENTRIES-1:0][PPN_BITS-1:0] ppn;
    logic [ENTRIES-1:0][7:0]          perms;
    logic [7:0]                       perms_or;

    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (!reset || clear_all)
                valid[i] <= 1'b0;
            else if (wr_en && wr_idx == IDX_W'(i))
                valid[i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (wr_en && wr_idx == IDX_W'(i)) begin
                vpn[i]   <= wr_vpn;
                ppn[i]   <= wr_ppn;
                perms[i] <= wr_perms;
            end
        end
    end

    // At most one entry matches, so an AND-OR mux is sufficient.
    always_comb begin
        hit      = 1'b0;
        hit_ppn  = '0;
        perms_or = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid[i] && vpn[i] == lookup_vpn) begin
                hit      = 1'b1;
                hit_ppn  = hit_ppn | ppn[i];
                perms_or = perms_or | perms[i];
            end
        end
    end

    assign hit_perms = tlb_perm_bits'(perms_or);

endmodule

// File: rtl/tlb.sv
// TLB control: lookup/walk/respond FSM, round-robin victim, root tracking, faults.
module tlb
    import mmu_pkg::*;
#(
    parameter int ENTRIES = 8
) (
    input logic  clk,
    input logic  reset,
    tlb_if.slave bus
);

    localparam int IDX_W = $clog2(ENTRIES);

    tlb_state_t          state;
    logic [IDX_W-1:0]    victim_ptr;
    logic [63:0]         last_root;
    logic [63:0]         walk_root;
    logic                hit;
    logic [PPN_BITS-1:0] hit_ppn;
    tlb_perm_bits        hit_perms;
    tlb_perm_bits        walk_perms;
    logic                inval;
    logic                abort;
    logic                install;
    logic                unused_walk_lo;

    assign walk_perms     = bus.walk_resp_perms;
    assign inval          = bus.flush || (bus.root_pt_addr != last_root);
    assign abort          = inval || (bus.root_pt_addr != walk_root);
    assign install        = (state == TLB_WALK) && bus.walk_resp_valid && walk_perms.valid && !abort;
    assign unused_walk_lo = ^bus.walk_resp_addr[PAGE_OFFSET_BITS-1:0];

    tlb_cam #(.ENTRIES(ENTRIES)) u_cam (
        .clk        (clk),
        .reset      (reset),
        .lookup_vpn (bus.req_addr[47:12]),
        .hit        (hit),
        .hit_ppn    (hit_ppn),
        .hit_perms  (hit_perms),
        .wr_en      (install),
        .wr_idx     (victim_ptr),
        .wr_vpn     (bus.walk_req_addr[47:12]),
        .wr_ppn     (bus.walk_resp_addr[63:12]),
        .wr_perms   (walk_perms),
        .clear_all  (inval)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state              <= TLB_IDLE;
            victim_ptr         <= '0;
            last_root          <= '0;
            walk_root          <= '0;
            bus.resp_valid     <= 1'b0;
            bus.resp_addr      <= '0;
            bus.resp_perms     <= '0;
            bus.resp_fault     <= 1'b0;
            bus.walk_req_valid <= 1'b0;
            bus.walk_req_addr  <= '0;
        end else begin
            last_root      <= bus.root_pt_addr;
            bus.resp_valid <= 1'b0;
            unique case (state)
                TLB_IDLE: begin
                    if (bus.req_valid) begin
                        // Entries being invalidated this edge must not hit.
                        if (hit && !inval) begin
                            bus.resp_valid <= 1'b1;
                            bus.resp_addr  <= {hit_ppn, bus.req_addr[PAGE_OFFSET_BITS-1:0]};
                            bus.resp_perms <= hit_perms;
                            bus.resp_fault <= tlb_fault(hit_perms, bus.req_write, bus.req_exec);
                            state          <= TLB_RESP;
                        end else begin
                            bus.walk_req_valid <= 1'b1;
                            bus.walk_req_addr  <= bus.req_addr;
                            walk_root          <= bus.root_pt_addr;
                            state              <= TLB_WALK;
                        end
                    end
                end
                TLB_WALK: begin
                    if (abort) begin
                        // Drop the walk; IDLE re-looks up the still-held request.
                        bus.walk_req_valid <= 1'b0;
                        state              <= TLB_IDLE;
                    end else if (bus.walk_resp_valid) begin
                        bus.walk_req_valid <= 1'b0;
                        bus.resp_valid     <= 1'b1;
                        bus.resp_addr      <= {bus.walk_resp_addr[63:12],
                                               bus.walk_req_addr[PAGE_OFFSET_BITS-1:0]};
                        if (walk_perms.valid) begin
                            bus.resp_perms <= walk_perms;
                            bus.resp_fault <= tlb_fault(walk_perms, bus.req_write, bus.req_exec);
                            victim_ptr     <= (victim_ptr == IDX_W'(ENTRIES - 1)) ? '0 : victim_ptr + 1'b1;
                        end else begin
                            bus.resp_perms <= '0;
                            bus.resp_fault <= 1'b1;
                        end
                        state <= TLB_RESP;
                    end
                end
                TLB_RESP: state <= TLB_IDLE;
                default:  state <= TLB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tlb.sv
// Directed bench for tlb: the bench plays requester and page walker.
module tb_tlb;
    import mmu_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    tlb_if bus ();

    tlb #(.ENTRIES(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic [63:0] va, input logic wr, input logic ex);
        bus.req_valid = 1'b1;
        bus.req_addr  = va;
        bus.req_write = wr;
        bus.req_exec  = ex;
    endtask

    task automatic drop_req();
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_exec  = 1'b0;
    endtask

    task automatic check_resp(input string tag, input logic [63:0] pa, input logic [7:0] perms,
                              input logic fault);
        chk({tag, ".resp_valid"}, 64'(bus.resp_valid), 64'd1);
        chk({tag, ".walk_off"},   64'(bus.walk_req_valid), 64'd0);
        chk({tag, ".addr"},       bus.resp_addr, pa);
        chk({tag, ".perms"},      64'(bus.resp_perms), 64'(perms));
        chk({tag, ".fault"},      64'(bus.resp_fault), 64'(fault));
    endtask

    // Expects a hit: response one cycle after the request is sampled, no walk.
    task automatic lookup_hit(input string tag, input logic [63:0] va, input logic wr,
                              input logic ex, input logic [63:0] pa, input logic [7:0] perms,
                              input logic fault);
        drive_req(va, wr, ex);
        @(negedge clk);
        check_resp(tag, pa, perms, fault);
        drop_req();
        @(negedge clk);
    endtask

    // Expects a miss: walk request next cycle, walker answers after lat extra cycles.
    task automatic lookup_miss(input string tag, input logic [63:0] va, input logic wr,
                               input logic ex, input int lat, input logic [63:0] wpa,
                               input logic [7:0] wperms, input logic [63:0] pa,
                               input logic [7:0] perms, input logic fault);
        drive_req(va, wr, ex);
        @(negedge clk);
        chk({tag, ".walk_req"},  64'(bus.walk_req_valid), 64'd1);
        chk({tag, ".no_resp"},   64'(bus.resp_valid), 64'd0);
        chk({tag, ".walk_addr"}, bus.walk_req_addr, va);
        repeat (lat) begin
            @(negedge clk);
            chk({tag, ".walk_hold"}, 64'(bus.walk_req_valid), 64'd1);
        end
        bus.walk_resp_valid = 1'b1;
        bus.walk_resp_addr  = wpa;
        bus.walk_resp_perms = tlb_perm_bits'(wperms);
        @(negedge clk);
        bus.walk_resp_valid = 1'b0;
        check_resp(tag, pa, perms, fault);
        drop_req();
        @(negedge clk);
    endtask

    initial begin
        bus.req_valid       = 1'b0;
        bus.req_addr        = '0;
        bus.req_write       = 1'b0;
        bus.req_exec        = 1'b0;
        bus.walk_resp_valid = 1'b0;
        bus.walk_resp_addr  = '0;
        bus.walk_resp_perms = '0;
        bus.root_pt_addr    = 64'h8000_0000;
        bus.flush           = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst.resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst.walk_valid", 64'(bus.walk_req_valid), 64'd0);
        chk("rst.resp_addr",  bus.resp_addr, 64'd0);
        chk("rst.walk_addr",  bus.walk_req_addr, 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Cold miss installs entry 0, then hits
        lookup_miss("cold", 64'h1234, 1'b0, 1'b0, 1, 64'h8_7000, 8'h0F, 64'h8_7234, 8'h0F, 1'b0);
        lookup_hit("cold_hit", 64'h1234, 1'b0, 1'b0, 64'h8_7234, 8'h0F, 1'b0);
        lookup_hit("hi_bits", 64'hFFFF_0000_0000_1234, 1'b0, 1'b0, 64'h8_7234, 8'h0F, 1'b0);
        lookup_hit("x_ok", 64'h1234, 1'b0, 1'b1, 64'h8_7234, 8'h0F, 1'b0);
        lookup_hit("w_ok", 64'h1FFC, 1'b1, 1'b0, 64'h8_7FFC, 8'h0F, 1'b0);

        // Page fault: no install, so the repeat walks again
        lookup_miss("pf", 64'h5000, 1'b0, 1'b0, 0, 64'h0, 8'h0E, 64'h0, 8'h00, 1'b1);
        lookup_miss("pf_again", 64'h5000, 1'b0, 1'b0, 2, 64'h0, 8'h00, 64'h0, 8'h00, 1'b1);

        // Read-only page (entry 1): store hits with fault
        lookup_miss("ro", 64'h2000, 1'b0, 1'b0, 0, 64'h9_1000, 8'h03, 64'h9_1000, 8'h03, 1'b0);
        lookup_hit("ro_write", 64'h2008, 1'b1, 1'b0, 64'h9_1008, 8'h03, 1'b1);
        lookup_hit("ro_exec", 64'h2010, 1'b0, 1'b1, 64'h9_1010, 8'h03, 1'b1);

        // Pages 3..8 fill entries 2..7, page 9 wraps onto entry 0 (page 1)
        for (int k = 3; k <= 9; k++)
            lookup_miss("fill", (64'(k) << 12) | 64'h10, 1'b0, 1'b0, 0, 64'(256 + k) << 12,
                        8'h0F, (64'(256 + k) << 12) | 64'h10, 8'h0F, 1'b0);
        lookup_hit("repl_p2", 64'h2004, 1'b0, 1'b0, 64'h9_1004, 8'h03, 1'b0);
        lookup_hit("repl_p9", 64'h9020, 1'b0, 1'b0, 64'h10_9020, 8'h0F, 1'b0);
        lookup_miss("repl_p1", 64'h1234, 1'b0, 1'b0, 0, 64'h8_7000, 8'h0F, 64'h8_7234, 8'h0F, 1'b0);

        // Flush mid-walk: walk abandoned, re-lookup walks again, one response
        drive_req(64'hA000, 1'b0, 1'b0);
        @(negedge clk);
        chk("fl.walk", 64'(bus.walk_req_valid), 64'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("fl.abort", 64'(bus.walk_req_valid), 64'd0);
        chk("fl.no_resp0", 64'(bus.resp_valid), 64'd0);
        @(negedge clk);
        chk("fl.rewalk", 64'(bus.walk_req_valid), 64'd1);
        chk("fl.no_resp1", 64'(bus.resp_valid), 64'd0);
        @(negedge clk);
        chk("fl.no_resp2", 64'(bus.resp_valid), 64'd0);
        bus.walk_resp_valid = 1'b1;
        bus.walk_resp_addr  = 64'hA_A000;
        bus.walk_resp_perms = tlb_perm_bits'(8'h0F);
        @(negedge clk);
        bus.walk_resp_valid = 1'b0;
        check_resp("fl", 64'hA_A000, 8'h0F, 1'b0);
        drop_req();
        @(negedge clk);
        chk("fl.single", 64'(bus.resp_valid), 64'd0);

        // Flush in the same cycle as the walk result: no install, no response
        drive_req(64'hD000, 1'b0, 1'b0);
        @(negedge clk);
        chk("flr.walk", 64'(bus.walk_req_valid), 64'd1);
        bus.flush           = 1'b1;
        bus.walk_resp_valid = 1'b1;
        bus.walk_resp_addr  = 64'hD_D000;
        bus.walk_resp_perms = tlb_perm_bits'(8'h0F);
        @(negedge clk);
        bus.flush           = 1'b0;
        bus.walk_resp_valid = 1'b0;
        chk("flr.no_resp", 64'(bus.resp_valid), 64'd0);
        chk("flr.abort", 64'(bus.walk_req_valid), 64'd0);
        @(negedge clk);
        chk("flr.rewalk", 64'(bus.walk_req_valid), 64'd1);
        bus.walk_resp_valid = 1'b1;
        @(negedge clk);
        bus.walk_resp_valid = 1'b0;
        check_resp("flr", 64'hD_D000, 8'h0F, 1'b0);
        drop_req();
        @(negedge clk);

        // Page 9 was cached before the flushes
        lookup_miss("fl_gone", 64'h9010, 1'b0, 1'b0, 0, 64'h10_9000, 8'h0F, 64'h10_9010, 8'h0F, 1'b0);

        // Root change invalidates everything
        lookup_miss("rootA", 64'hB000, 1'b0, 1'b0, 0, 64'hB_B000, 8'h0F, 64'hB_B000, 8'h0F, 1'b0);
        lookup_hit("rootA_hit", 64'hB123, 1'b0, 1'b0, 64'hB_B123, 8'h0F, 1'b0);
        bus.root_pt_addr = 64'h9000_0000;
        @(negedge clk);
        lookup_miss("rootA_new", 64'hB123, 1'b0, 1'b0, 0, 64'hB_C000, 8'h0F, 64'hB_C123, 8'h0F, 1'b0);

        // Reset mid-walk clears every output next cycle
        drive_req(64'hC000, 1'b0, 1'b0);
        @(negedge clk);
        chk("rstw.walk", 64'(bus.walk_req_valid), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("rstw.walk_valid", 64'(bus.walk_req_valid), 64'd0);
        chk("rstw.walk_addr",  bus.walk_req_addr, 64'd0);
        chk("rstw.resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rstw.resp_addr",  bus.resp_addr, 64'd0);
        chk("rstw.resp_perms", 64'(bus.resp_perms), 64'd0);
        chk("rstw.resp_fault", 64'(bus.resp_fault), 64'd0);
        drop_req();
        reset = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
